// File: rtl/fifo_pkg.sv
// Shared geometry defaults for the single-clock FIFO.
// The pointer width is derived here so every user agrees on it.
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 64;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Dual-port storage array for the FIFO: synchronous write, registered read.
// Only the read-data register is reset; the array contents are left as they are.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read register holds its value on every cycle without an accepted read.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : fifo_mem

// File: rtl/fifo_single_clock.sv
// Single-clock synchronous FIFO with registered read data and full/empty flags.
// Pointer/counter control lives here; storage lives in fifo_mem.
module fifo_single_clock
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] buf_in,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] buf_out,
    output logic             buf_empty,
    output logic             buf_full
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_accept;
    logic          rd_accept;

    // Handshake: a request is a one-cycle enable with no ready/ack. A write is
    // taken when wr_en is high and the FIFO is not full, a read when rd_en is
    // high and it is not empty; anything else is dropped without a trace.
    // When empty, a simultaneous read is refused so the new word is not bypassed.
    assign wr_accept = wr_en && !buf_full;
    assign rd_accept = rd_en && !buf_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_accept, rd_accept})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign buf_empty = (cnt_q == '0);
    assign buf_full  = (cnt_q == CNT_FULL);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (buf_in),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (buf_out)
    );

    cnt_in_range_a : assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_FULL);

endmodule : fifo_single_clock

// File: tb/tb_fifo_single_clock.sv
// Bench for fifo_single_clock: vector table, hand-written corner sequences and
// a random phase, all checked against a queue-based reference FIFO.
module tb_fifo_single_clock;

    localparam int W     = 16;
    localparam int DEPTH = 64;

    logic         clk;
    logic         rst;
    logic [W-1:0] buf_in;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] buf_out;
    logic         buf_empty;
    logic         buf_full;

    int checks;
    int errors;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_out;

    typedef struct {
        logic         rst;
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        logic         exp_empty;
        logic         exp_full;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vecs[9];

    fifo_single_clock #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .buf_in    (buf_in),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .buf_out   (buf_out),
        .buf_empty (buf_empty),
        .buf_full  (buf_full)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, update the reference
    // FIFO for the rising edge, then sample 1ns after it and compare.
    task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
        logic wr_ok;
        logic rd_ok;
        @(negedge clk);
        rst    = r;
        wr_en  = w;
        rd_en  = rd;
        buf_in = d;
        wr_ok  = w && (exp_q.size() < DEPTH);
        rd_ok  = rd && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            exp_out = '0;
        end else begin
            if (rd_ok) exp_out = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(d);
        end
        check("sb_buf_out", buf_out, exp_out);
        check("sb_empty", W'(buf_empty), W'(exp_q.size() == 0));
        check("sb_full", W'(buf_full), W'(exp_q.size() == DEPTH));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_out = '0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        buf_in  = '0;

        //          rst   wr    rd    din       empty full  out
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'hFFFF};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'hFFFF};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b0, 16'h1234};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h9ABC, 1'b0, 1'b0, 16'h5678};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h9ABC};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h9ABC};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d_out", i), buf_out, vecs[i].exp_out);
            check($sformatf("vec%0d_empty", i), W'(buf_empty), W'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i), W'(buf_full), W'(vecs[i].exp_full));
        end

        // burst of 11 words, then read past empty
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, W'(i));
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'h0000);
            if (i < 11) check("burst_order", buf_out, W'(i));
        end
        check("burst_hold", buf_out, 16'h000A);
        check("burst_empty", W'(buf_empty), 16'h0001);

        // fill across pointer wrap, overflow, then drain
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0, 16'h1000 + W'(i));
        check("fill_full", W'(buf_full), 16'h0001);
        step(1'b0, 1'b1, 1'b0, 16'hDEAD);
        check("overflow_full", W'(buf_full), 16'h0001);
        step(1'b0, 1'b1, 1'b1, 16'hBAD0);
        check("full_rdwr_out", buf_out, 16'h1000);
        check("full_rdwr_notfull", W'(buf_full), 16'h0000);
        for (int i = 1; i < 64; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'h0000);
            check("drain_order", buf_out, 16'h1000 + W'(i));
        end
        check("drain_empty", W'(buf_empty), 16'h0001);

        // reset in the middle of operation, with a write in the same cycle
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'h2000 + W'(i));
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        check("pre_rst_out", buf_out, 16'h2000);
        step(1'b1, 1'b1, 1'b0, 16'hBEEF);
        check("rst_empty", W'(buf_empty), 16'h0001);
        check("rst_out", buf_out, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        check("rst_write_dropped", buf_out, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0077);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        check("post_rst_data", buf_out, 16'h0077);

        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 45, W'($urandom_range(0, 65535)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_single_clock
